// File: rtl/nl_noc_pkg.sv
// -----------------------------------------------------------------------------
// nl_noc_pkg -- shared types and helpers for the NL NoC router.
//   flit_t       : flit with control header (valid, tail, vc_id, output_port,
//                  vn, drop, vcalloc_mask) and a 32-bit payload.
//   fifo_flags_t : per-VC FIFO status {full, empty, nearly_full, nearly_empty}.
//   vc_index_t   : binary VC index, max(1, clogb2(NVS)) bits wide.
//   clogb2()     : ceil(log2(value)), with clogb2(1) == 0.
//   oh2bin()     : one-hot to binary index (OR of set-bit positions).
// -----------------------------------------------------------------------------
package nl_noc_pkg;

  localparam int NVS    = 4;
  localparam int DATA_W = 32;

  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // The OR of set-bit positions is exact for one-hot input.
  function automatic int oh2bin(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      idx = idx | (oh[i] ? i : 0);
    end
    return idx;
  endfunction

  localparam int VC_W = (clogb2(NVS) > 0) ? clogb2(NVS) : 1;

  typedef logic [VC_W-1:0] vc_index_t;

  typedef struct packed {
    logic            valid;
    logic            tail;
    vc_index_t       vc_id;
    logic [2:0]      output_port;
    logic [0:0]      vn;
    logic            drop;
    logic [NVS-1:0]  vcalloc_mask;
  } flit_ctrl_t;

  typedef struct packed {
    flit_ctrl_t         control;
    logic [DATA_W-1:0]  data;
  } flit_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic nearly_full;
    logic nearly_empty;
  } fifo_flags_t;

endpackage

// File: rtl/nl_vc_buffers_chk.sv
// -----------------------------------------------------------------------------
// nl_vc_buffers_chk -- simulation-only protocol checker for nl_vc_buffers.
// Present only when NL_VC_BUF_CHECK_EN is defined. Reports, per VC:
// push to full without pop, pop of empty, non-one-hot select, vc_id >= n.
//   clk, rst_n, push, vc_id, pop, select : observed copies of the DUT inputs
//   flags                                : DUT status flags
// -----------------------------------------------------------------------------
`ifdef NL_VC_BUF_CHECK_EN
module nl_vc_buffers_chk
  import nl_noc_pkg::*;
#(
  parameter int n    = 4,
  parameter int vc_w = 2
) (
  input logic                clk,
  input logic                rst_n,
  input logic                push,
  input logic [vc_w-1:0]     vc_id,
  input logic [n-1:0]        pop,
  input logic [n-1:0]        select,
  input fifo_flags_t [n-1:0] flags
);

  // Flag illegal uses at each sampling edge while out of reset.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < n; i++) begin
        if (push && (vc_id == vc_w'(i)) && flags[i].full && !pop[i])
          $error("nl_vc_buffers: push to full VC %0d dropped", i);
        if (pop[i] && flags[i].empty)
          $error("nl_vc_buffers: pop of empty VC %0d", i);
      end
      if ($countones(select) > 1)
        $error("nl_vc_buffers: select %b names more than one VC", select);
      if (push && (32'(vc_id) >= n))
        $error("nl_vc_buffers: push to nonexistent VC %0d", vc_id);
    end
  end

endmodule
`endif

// File: rtl/nl_vc_fifo.sv
// -----------------------------------------------------------------------------
// nl_vc_fifo -- one size-deep first-word-fall-through FIFO for a single VC.
//   clk, rst_n : clock, async active-low reset (pointers/count/flags only)
//   push       : store data_in at tail (dropped when full unless popping)
//   pop        : advance head (ignored when empty)
//   data_in    : element to store
//   data_out   : head element, '0 when empty (combinational)
//   flags      : registered {full, empty, nearly_full, nearly_empty}
// Pointers wrap modulo size, so size need not be a power of two.
// -----------------------------------------------------------------------------
module nl_vc_fifo
  import nl_noc_pkg::*;
#(
  parameter int  size            = 4,
  parameter type fifo_elements_t = flit_t
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  fifo_elements_t data_in,
  output fifo_elements_t data_out,
  output fifo_flags_t    flags
);

  localparam int ptr_w = clogb2(size);
  localparam int cnt_w = clogb2(size + 1);

  fifo_elements_t    mem_r [size];
  logic [ptr_w-1:0]  head_r;
  logic [ptr_w-1:0]  tail_r;
  logic [cnt_w-1:0]  count_r;
  logic [cnt_w-1:0]  count_nxt_s;
  logic              do_push_s;
  logic              do_pop_s;
  fifo_flags_t       flags_r;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(size - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  // Qualify push/pop against occupancy; a pop frees the slot for a same-cycle push.
  always_comb begin
    do_pop_s    = pop && (count_r != '0);
    do_push_s   = push && ((count_r != cnt_w'(size)) || do_pop_s);
    count_nxt_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + cnt_w'(1);
      2'b01:   count_nxt_s = count_r - cnt_w'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and status-flag registers; flags follow the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      flags_r <= '{full: 1'b0, empty: 1'b1, nearly_full: 1'b0, nearly_empty: 1'b0};
    end else begin
      if (do_pop_s) begin
        head_r <= ptr_inc(head_r);
      end
      if (do_push_s) begin
        tail_r <= ptr_inc(tail_r);
      end
      count_r              <= count_nxt_s;
      flags_r.full         <= (count_nxt_s == cnt_w'(size));
      flags_r.empty        <= (count_nxt_s == '0);
      flags_r.nearly_full  <= (count_nxt_s == cnt_w'(size - 1));
      flags_r.nearly_empty <= (count_nxt_s == cnt_w'(1));
    end
  end

  // Element storage; deliberately not reset, the count decides what is live.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[tail_r] <= data_in;
    end
  end

  // Fall-through head read, forced to zero when nothing is stored.
  always_comb begin
    if (count_r != '0) begin
      data_out = mem_r[head_r];
    end else begin
      data_out = '0;
    end
  end

  assign flags = flags_r;

endmodule

// File: rtl/nl_vc_buffers.sv
// -----------------------------------------------------------------------------
// nl_vc_buffers -- per-input-port bank of n independent VC flit FIFOs.
//   clk, rst_n : clock, async active-low reset
//   push       : write data_in into FIFO[vc_id] (vc_id >= n ignored)
//   data_in    : flit to store
//   vc_id      : binary target VC, max(1, clogb2(nvs)) bits
//   pop[n]     : pop[i] removes the head of FIFO[i]
//   select[n]  : one-hot; chosen VC head drives data_out ('0 if none/empty)
//   data_out   : head flit of the selected VC (combinational)
//   flags[n]   : per-VC {full, empty, nearly_full, nearly_empty}
// Optional macro NL_VC_BUF_CHECK_EN enables the simulation protocol checker.
// -----------------------------------------------------------------------------
module nl_vc_buffers
  import nl_noc_pkg::*;
#(
  parameter int  size            = 4,
  parameter int  nvs             = 4,
  parameter int  n               = 4,
  parameter type fifo_elements_t = flit_t,
  localparam int vc_w            = (clogb2(nvs) > 0) ? clogb2(nvs) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  fifo_elements_t      data_in,
  input  logic [vc_w-1:0]     vc_id,
  input  logic [n-1:0]        pop,
  input  logic [n-1:0]        select,
  output fifo_elements_t      data_out,
  output fifo_flags_t [n-1:0] flags
);

  localparam int idx_w = (clogb2(n) > 0) ? clogb2(n) : 1;

  fifo_elements_t head_s [n];
  logic [n-1:0]   push_s;
  int             oh_idx_s;

  for (genvar gi = 0; gi < n; gi++) begin : g_vc
    // vc_id values at or above n match no instance, so such pushes vanish.
    assign push_s[gi] = push && (vc_id == vc_w'(gi));

    nl_vc_fifo #(
      .size            (size),
      .fifo_elements_t (fifo_elements_t)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push_s[gi]),
      .pop      (pop[gi]),
      .data_in  (data_in),
      .data_out (head_s[gi]),
      .flags    (flags[gi])
    );
  end

  // Output mux: empty FIFOs already present '0, so only no-select needs care.
  always_comb begin
    oh_idx_s = oh2bin(32'(select));
    if ((select != '0) && (oh_idx_s < n)) begin
      data_out = head_s[oh_idx_s[idx_w-1:0]];
    end else begin
      data_out = '0;
    end
  end

`ifdef NL_VC_BUF_CHECK_EN
  nl_vc_buffers_chk #(
    .n    (n),
    .vc_w (vc_w)
  ) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .vc_id  (vc_id),
    .pop    (pop),
    .select (select),
    .flags  (flags)
  );
`endif

endmodule

// File: tb/tb_nl_vc_buffers.sv
// -----------------------------------------------------------------------------
// tb_nl_vc_buffers -- directed plus random bench for nl_vc_buffers.
// Reference: one queue per VC; each cycle applies the pop/push rules to the
// queues and the expected flags/data_out are derived from queue lengths/heads.
// -----------------------------------------------------------------------------
module tb_nl_vc_buffers;
  import nl_noc_pkg::*;

  localparam int SIZE = 4;
  localparam int N    = 4;

  logic               clk     = 1'b0;
  logic               rst_n   = 1'b0;
  logic               push    = 1'b0;
  flit_t              data_in = '0;
  logic [1:0]         vc_id   = 2'd0;
  logic [N-1:0]       pop     = '0;
  logic [N-1:0]       select  = '0;
  flit_t              data_out;
  fifo_flags_t [N-1:0] flags;

  int    checks   = 0;
  int    failures = 0;
  flit_t q [N][$];

  nl_vc_buffers #(
    .size            (SIZE),
    .nvs             (4),
    .n               (N),
    .fifo_elements_t (flit_t)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .data_in  (data_in),
    .vc_id    (vc_id),
    .pop      (pop),
    .select   (select),
    .data_out (data_out),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Order matches fifo_flags_t: {full, empty, nearly_full, nearly_empty}.
  function automatic logic [3:0] exp_flags(input int sz);
    return {(sz == SIZE), (sz == 0), (sz == SIZE - 1), (sz == 1)};
  endfunction

  function automatic flit_t exp_out(input logic [N-1:0] sel);
    for (int i = 0; i < N; i++) begin
      if (sel[i]) return (q[i].size() > 0) ? q[i][0] : '0;
    end
    return '0;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s.flags%0d", tag, i), 64'(flags[i]), 64'(exp_flags(q[i].size())));
    chk($sformatf("%s.data_out", tag), 64'(data_out), 64'(exp_out(select)));
  endtask

  task automatic model_edge(input logic p, input logic [1:0] v, input flit_t d,
                            input logic [N-1:0] pp);
    for (int i = 0; i < N; i++) begin
      bit popped, pushed;
      popped = pp[i] && (q[i].size() > 0);
      pushed = p && (int'(v) == i) && ((q[i].size() < SIZE) || popped);
      if (popped) void'(q[i].pop_front());
      if (pushed) q[i].push_back(d);
    end
  endtask

  task automatic cyc(input logic p, input logic [1:0] v, input flit_t d,
                     input logic [N-1:0] pp, input logic [N-1:0] sel, input string tag);
    push = p; vc_id = v; data_in = d; pop = pp; select = sel;
    @(posedge clk);
    model_edge(p, v, d, pp);
    #1;
    push = 1'b0; pop = '0;
    check_all(tag);
  endtask

  function automatic flit_t mk(input int tagv);
    flit_t f;
    f = '0;
    f.control.valid = 1'b1;
    f.control.tail  = tagv[0];
    f.data          = 32'hA5A5_0000 | 32'(tagv);
    return f;
  endfunction

  function automatic flit_t rnd_flit();
    logic [63:0] r;
    flit_t f;
    r = {$urandom, $urandom};
    f = r[$bits(flit_t)-1:0];
    f.control.valid = 1'b1;
    return f;
  endfunction

  initial begin
    flit_t seq [4];
    flit_t e_flit, x_flit, y_flit, z_flit;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    select = 4'b0001;
    #1;
    check_all("reset");
    chk("reset.flags0_const", 64'(flags[0]), 64'(4'b0100));

    // 1. Async reset mid-stream with three flits in VC1
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd1, mk(i + 1), 4'b0000, 4'b0010, "t1.fill");
    chk("t1.head", 64'(data_out), 64'(mk(1)));
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    select = 4'b0001;
    #1;
    check_all("t1.rst");
    chk("t1.flags1_const", 64'(flags[1]), 64'(4'b0100));
    select = 4'b0010;
    #1;
    chk("t1.vc1_out", 64'(data_out), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // 2. Fill VC2, overflow dropped, drain in order
    for (int i = 0; i < 4; i++) seq[i] = mk(16'h0A + i);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'd2, seq[i], 4'b0000, 4'b0100, "t2.fill");
      if (i == 2) chk("t2.nearly_full", 64'(flags[2].nearly_full), 64'(1'b1));
    end
    chk("t2.full", 64'(flags[2].full), 64'(1'b1));
    cyc(1'b1, 2'd2, mk(16'hEE), 4'b0000, 4'b0100, "t2.overflow");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2.order%0d", i), 64'(data_out), 64'(seq[i]));
      cyc(1'b0, 2'd0, '0, 4'b0100, 4'b0100, "t2.drain");
    end

    // 3. Full VC0: push and pop in the same cycle
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'd0, mk(16'h20 + i), 4'b0000, 4'b0001, "t3.fill");
    e_flit = mk(16'hE0);
    cyc(1'b1, 2'd0, e_flit, 4'b0001, 4'b0001, "t3.pushpop");
    chk("t3.full_held", 64'(flags[0].full), 64'(1'b1));
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, '0, 4'b0001, 4'b0001, "t3.drain");
    chk("t3.last_is_E", 64'(data_out), 64'(e_flit));
    cyc(1'b0, 2'd0, '0, 4'b0001, 4'b0001, "t3.drain");

    // 4. Isolation between VC0 and VC3, dual pop
    x_flit = mk(16'h58);
    y_flit = mk(16'h59);
    cyc(1'b1, 2'd0, x_flit, 4'b0000, 4'b0000, "t4.push_x");
    cyc(1'b1, 2'd3, y_flit, 4'b0000, 4'b0000, "t4.push_y");
    select = 4'b1000;
    #1;
    chk("t4.sel3", 64'(data_out), 64'(y_flit));
    select = 4'b0001;
    #1;
    chk("t4.sel0", 64'(data_out), 64'(x_flit));
    cyc(1'b0, 2'd0, '0, 4'b1001, 4'b0001, "t4.dualpop");

    // 5. Underflow on empty VC1
    cyc(1'b0, 2'd0, '0, 4'b0010, 4'b0010, "t5.underflow");
    chk("t5.flags1_const", 64'(flags[1]), 64'(4'b0100));

    // 6. Fall-through into empty VC1
    z_flit = mk(16'h5A);
    cyc(1'b1, 2'd1, z_flit, 4'b0000, 4'b0010, "t6.push");
    chk("t6.fallthrough", 64'(data_out), 64'(z_flit));
    cyc(1'b0, 2'd0, '0, 4'b0010, 4'b0010, "t6.pop");

    // Random traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      logic         p;
      logic [1:0]   v;
      logic [N-1:0] pp, sel;
      int           s;
      p  = ($urandom_range(0, 99) < 60);
      v  = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) pp[i] = ($urandom_range(0, 99) < 30);
      s   = $urandom_range(0, 4);
      sel = (s == 4) ? 4'b0000 : 4'(1 << s);
      cyc(p, v, rnd_flit(), pp, sel, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
